bus_arbiter_n: RTL and testbench
================================

# bus_arbiter_n

Parametrised N-master bus arbiter that owns the single shared bus's grant. It holds exactly one one-hot grant at all times and parks on a configurable default master when idle. An owner keeps the bus for as long as it requests it, and the next owner is chosen by fixed-priority or round-robin arbitration. An optional tenure limit forcibly hands the bus over when a master monopolises it while others wait.

## Interface
- N_MASTERS, 4: number of requesting masters; legal range 2..16.
- PARK_ID, 0: master granted out of reset and when no master requests.
- ARB_MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- MAX_TENURE, 16: cycles an owner may hold the bus while others wait. Used only with the timeout feature; legal range 2..255.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- req  input  N_MASTERS  per-master bus request, level-sensitive.
- grant  output  N_MASTERS  registered one-hot grant.
- grant_id  output  $clog2(N_MASTERS)  binary index of the current owner; registered and consistent with grant.
- preempt  output  1  one-cycle pulse, registered, coincident with the first cycle of a grant taken by timeout.

## Operation
- Reset (asynchronous): grant = 1<<PARK_ID, grant_id = PARK_ID, preempt = 0, tenure counter = 0, round-robin pointer = PARK_ID.
- Grant is never all-zero and never has more than one bit set.
- Hold rule: if req[owner] = 1, the owner keeps the bus. The only exception is preemption by the tenure limit.
- Release rule: if req[owner] = 0 and any other req bit is set, the next owner is selected and the grant moves at the next edge.
  - ARB_MODE 0: the lowest set index wins.
  - ARB_MODE 1: search starts at owner+1 and wraps modulo N_MASTERS; the first set bit wins.
- Idle rule: if req = 0, the grant moves to PARK_ID, or stays there if already parked.
- Parked master with req[PARK_ID] = 0: any other request takes the bus at the next edge.
- A master that drops its request and re-raises it on the next cycle does not retain the bus. Arbitration re-runs on the sampled req vector.
- Requests from non-owners are not latched. A pulse that is low at the deciding edge is lost.
- Round-robin pointer = last granted index. It is updated on every grant change, including parking.

## Timing
- Decision latency: 1 cycle. A req change sampled at edge k is reflected on grant after edge k.
- Bus hand-over costs no dead cycles: the old owner's last grant cycle is immediately followed by the new owner's first.
- grant, grant_id and preempt all update on the same edge.
- reset_n assertion mid-tenure returns to the reset state immediately. The first arbitration happens at the first edge after deassertion.

## Configuration
- BUS_ARBITER_TIMEOUT_EN defined:
  - An 8-bit tenure counter clears on every grant change.
  - It increments each cycle the owner holds the bus while any other req bit is set, saturating at MAX_TENURE.
  - It holds its value when no other master requests.
  - When counter = MAX_TENURE-1 and another request is still pending at the next edge, the grant moves to the next requester chosen by ARB_MODE with the owner excluded, and preempt pulses for one cycle.
- Not defined: no counter; preempt is tied to 0; the hold rule is absolute.

## Structure
- Shared package bus_arb_pkg:
  - ARB_FIXED and ARB_RR mode constants.
  - The tenure counter width constant.
  - The onehot-to-index function, also used by the slave decoders.
- Sub-module rr_pick: combinational masked priority picker. Inputs are a request vector and a base index; outputs are a one-hot winner and a valid flag. Fixed mode uses base = 0.
- Top level contains the grant/id registers, the pointer, and the optional counter.

## Test plan
- Reset, N_MASTERS=4, PARK_ID=2: grant = 4'b0100 and grant_id = 2 during reset and on the first edge after it with req = 0.
- Owner hold, RR mode: master 1 is owner with req = 4'b1111 held for 10 cycles. grant stays 4'b0010 throughout (timeout off).
- Rotation, RR mode: owner 1 drops req with req = 4'b1101 → next grant 4'b0100 (master 2). Master 2 drops → 4'b1000. Master 3 drops → 4'b0001.
- Fixed mode: owner 3 drops with req = 4'b0110 → grant 4'b0010. All req = 0 → grant returns to PARK_ID one cycle later.
- Timeout (BUS_ARBITER_TIMEOUT_EN, MAX_TENURE=4): master 0 holds with req = 4'b1001 from cycle 0. The grant moves to 4'b1000 after exactly 4 held cycles, and preempt = 1 for that one cycle only.
- Mid-tenure reset: reset_n is pulsed low asynchronously between edges while master 3 owns the bus → grant = 1<<PARK_ID immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared arbitration constants and the one-hot to index helper.
// Latency: none (constants and a combinational function only).
// Backpressure: not applicable.
// Contents: ARB_FIXED/ARB_RR mode codes, tenure counter width, onehot_to_idx()
// (also used by the slave-side address/grant decoders).
package bus_arb_pkg;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;
    localparam int TENURE_W    = 8;
    localparam int MAX_MASTERS = 16;

    // Binary index of a one-hot vector; returns 0 for an all-zero input.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_n_rr_pick.sv
// Masked priority picker: first set request at or after 'base', wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to use the winner.
// Ports: req (request vector), base (search start index),
//        gnt (one-hot winner), vld (any request present).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    // Rotate requests so 'base' lands on bit 0, pick the lowest set bit,
    // then rotate the winner back into place.
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt_dbl;

    always_comb begin
        req_dbl = {req, req} >> base;
        rot_req = req_dbl[N-1:0];
        rot_gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_gnt    = '0;
                rot_gnt[i] = 1'b1;
            end
        end
        gnt_dbl = {rot_gnt, rot_gnt} << base;
        gnt     = gnt_dbl[2*N-1:N];
        vld     = |req;
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master shared-bus arbiter: registered one-hot grant, parks on PARK_ID.
// Latency: 1 cycle from sampled req to grant; hand-over has no dead cycle.
// Backpressure: none; owner holds while req is high, req is level-sensitive.
// Ports: clk, reset_n (async active-low), req[N], grant[N] (one-hot),
//        grant_id (owner index), preempt (pulse on a timeout hand-over).
// Build option: BUS_ARBITER_TIMEOUT_EN enables the MAX_TENURE tenure limit.
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int PARK_ID    = 0,
    parameter int ARB_MODE   = 1,
    parameter int MAX_TENURE = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_MASTERS-1:0]         req,
    output logic [N_MASTERS-1:0]         grant,
    output logic [$clog2(N_MASTERS)-1:0] grant_id,
    output logic                         preempt
);

    localparam int IW = $clog2(N_MASTERS);
    localparam logic [N_MASTERS-1:0] PARK_GNT = {{(N_MASTERS-1){1'b0}}, 1'b1} << PARK_ID;
    localparam logic [IW-1:0]        PARK_IDX = IW'(PARK_ID);

    if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS) begin : g_bad_n
        $error("bus_arbiter_n: N_MASTERS out of range 2..16");
    end
    if (PARK_ID < 0 || PARK_ID >= N_MASTERS) begin : g_bad_park
        $error("bus_arbiter_n: PARK_ID must index a master");
    end
    if (MAX_TENURE < 2 || MAX_TENURE > 255) begin : g_bad_tenure
        $error("bus_arbiter_n: MAX_TENURE out of range 2..255");
    end

    logic [N_MASTERS-1:0] pick_req;
    logic [N_MASTERS-1:0] pick_gnt;
    logic                 pick_vld;
    logic [IW-1:0]        pick_id;
    logic [IW-1:0]        pick_base;
    logic                 owner_req;
    logic [N_MASTERS-1:0] nxt_gnt;
    logic [IW-1:0]        nxt_id;

    // The owner is excluded from the search: on release its req is already
    // low, and on preemption it must not win again.
    assign pick_req  = req & ~grant;
    assign owner_req = |(req & grant);

    // grant_id doubles as the round-robin pointer (last granted index, which
    // includes parking), so the search starts just past it.
    always_comb begin
        pick_base = '0;
        if (ARB_MODE == ARB_RR) begin
            pick_base = (grant_id == IW'(N_MASTERS - 1)) ? '0 : grant_id + IW'(1);
        end
    end

    rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req  (pick_req),
        .base (pick_base),
        .gnt  (pick_gnt),
        .vld  (pick_vld)
    );

    assign pick_id = IW'(onehot_to_idx(MAX_MASTERS'(pick_gnt)));

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [TENURE_W-1:0] TENURE_LAST = TENURE_W'(MAX_TENURE - 1);
    localparam logic [TENURE_W-1:0] TENURE_MAX  = TENURE_W'(MAX_TENURE);

    logic [TENURE_W-1:0] tenure;
    logic                take_to;
`endif

    always_comb begin
        nxt_gnt = grant;
        nxt_id  = grant_id;
`ifdef BUS_ARBITER_TIMEOUT_EN
        take_to = 1'b0;
`endif
        if (!owner_req) begin
            if (pick_vld) begin
                nxt_gnt = pick_gnt;
                nxt_id  = pick_id;
            end else begin
                nxt_gnt = PARK_GNT;
                nxt_id  = PARK_IDX;
            end
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (pick_vld && tenure == TENURE_LAST) begin
            nxt_gnt = pick_gnt;
            nxt_id  = pick_id;
            take_to = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= PARK_GNT;
            grant_id <= PARK_IDX;
        end else begin
            grant    <= nxt_gnt;
            grant_id <= nxt_id;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Counts contended held cycles; frozen while nobody else is waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tenure  <= '0;
            preempt <= 1'b0;
        end else begin
            preempt <= take_to;
            if (nxt_gnt != grant) begin
                tenure <= '0;
            end else if (owner_req && pick_vld && tenure != TENURE_MAX) begin
                tenure <= tenure + TENURE_W'(1);
            end
        end
    end
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_n.sv
module tb_bus_arbiter_n;

    localparam int NM   = 4;
    localparam int PARK = 2;
    localparam int MAXT = 4;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant_fx, grant_rr;
    logic [1:0] id_fx, id_rr;
    logic       pre_fx, pre_rr;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    exp_t q_fx[$];
    exp_t q_rr[$];

    // Reference state per mode: index 0 = fixed priority, 1 = round-robin.
    int   m_owner[2];
    int   m_held[2];

    always #5 clk = ~clk;

    bus_arbiter_n #(.N_MASTERS(NM), .PARK_ID(PARK), .ARB_MODE(0), .MAX_TENURE(MAXT)) dut_fx (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(grant_fx), .grant_id(id_fx), .preempt(pre_fx)
    );

    bus_arbiter_n #(.N_MASTERS(NM), .PARK_ID(PARK), .ARB_MODE(1), .MAX_TENURE(MAXT)) dut_rr (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(grant_rr), .grant_id(id_rr), .preempt(pre_rr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner among r: mode 0 lowest index, mode 1 first after owner (wrapping).
    function automatic int choose(input logic [3:0] r, input int mode, input int owner);
        for (int k = 0; k < NM; k++) begin
            int idx;
            idx = (mode == 1) ? (owner + 1 + k) % NM : k;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = PARK;
            m_held[m]  = 0;
        end
    endtask

    task automatic model_step(input int m, input logic [3:0] r, output exp_t e);
        int         own;
        int         nxt;
        bit         pre;
        logic [3:0] others;
        own    = m_owner[m];
        others = r & ~(4'b0001 << own);
        nxt    = own;
        pre    = 1'b0;
        if (r[own]) begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            if (others != 0 && m_held[m] == MAXT - 1) begin
                nxt = choose(others, m, own);
                pre = 1'b1;
            end
`endif
        end else if (r != 0) begin
            nxt = choose(r, m, own);
        end else begin
            nxt = PARK;
        end
        if (nxt != own) m_held[m] = 0;
        else if (r[own] && others != 0 && m_held[m] < MAXT) m_held[m]++;
        m_owner[m] = nxt;
        e.g  = 4'b0001 << nxt;
        e.id = 2'(nxt);
        e.p  = pre;
    endtask

    // Apply req for the next rising edge and queue what it must produce.
    task automatic drive(input logic [3:0] r);
        exp_t e;
        @(negedge clk);
        req = r;
        model_step(0, r, e);
        q_fx.push_back(e);
        model_step(1, r, e);
        q_rr.push_back(e);
        mon_en = 1'b1;
    endtask

    // Monitor: one expected response per active edge while enabled.
    always @(posedge clk) begin
        if (mon_en) begin
            exp_t e;
            #1;
            chk("fx_onehot", 32'($onehot(grant_fx)), 32'd1);
            chk("rr_onehot", 32'($onehot(grant_rr)), 32'd1);
            if (q_fx.size() == 0 || q_rr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
            end else begin
                e = q_fx.pop_front();
                chk("fx_grant", 32'(grant_fx), 32'(e.g));
                chk("fx_id", 32'(id_fx), 32'(e.id));
                chk("fx_preempt", 32'(pre_fx), 32'(e.p));
                e = q_rr.pop_front();
                chk("rr_grant", 32'(grant_rr), 32'(e.g));
                chk("rr_id", 32'(id_rr), 32'(e.id));
                chk("rr_preempt", 32'(pre_rr), 32'(e.p));
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        reset_n = 1'b0;
        req     = 4'b0000;
        model_reset();

        // Reset state, held across several edges.
        #22;
        chk("rst_grant", 32'(grant_rr), 32'h4);
        chk("rst_id", 32'(id_rr), 32'd2);
        chk("rst_preempt", 32'(pre_rr), 32'd0);
        chk("rst_grant_fx", 32'(grant_fx), 32'h4);
        @(negedge clk);
        reset_n = 1'b1;

        // First edge after reset with no requests stays parked.
        drive(4'b0000);
        after_edge();
        chk("park_after_rst", 32'(grant_rr), 32'h4);

        // Owner hold.
        drive(4'b0010);
        after_edge();
        chk("take_m1", 32'(grant_rr), 32'h2);
        for (int i = 0; i < 10; i++) begin
            drive(4'b1111);
            after_edge();
`ifndef BUS_ARBITER_TIMEOUT_EN
            chk("hold_m1", 32'(grant_rr), 32'h2);
`endif
        end

        // Round-robin rotation.
        drive(4'b1101);
        after_edge();
`ifndef BUS_ARBITER_TIMEOUT_EN
        chk("rot_to_2", 32'(grant_rr), 32'h4);
`endif
        drive(4'b1001);
        after_edge();
`ifndef BUS_ARBITER_TIMEOUT_EN
        chk("rot_to_3", 32'(grant_rr), 32'h8);
`endif
        drive(4'b0001);
        after_edge();
        chk("rot_to_0", 32'(grant_rr), 32'h1);

        // Fixed priority and return to park.
        drive(4'b1000);
        after_edge();
        chk("fx_take_3", 32'(grant_fx), 32'h8);
        drive(4'b0110);
        after_edge();
        chk("fx_lowest", 32'(grant_fx), 32'h2);
        drive(4'b0000);
        after_edge();
        chk("fx_park", 32'(grant_fx), 32'h4);
        chk("fx_park_id", 32'(id_fx), 32'd2);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Tenure limit: master 0 held against master 3.
        drive(4'b0001);
        after_edge();
        chk("to_take_0", 32'(grant_rr), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b1001);
            after_edge();
            chk("to_hold_0", 32'(grant_rr), 32'h1);
            chk("to_no_pre", 32'(pre_rr), 32'd0);
        end
        drive(4'b1001);
        after_edge();
        chk("to_move_3", 32'(grant_rr), 32'h8);
        chk("to_preempt", 32'(pre_rr), 32'd1);
        chk("to_preempt_fx", 32'(pre_fx), 32'd1);
        drive(4'b1001);
        after_edge();
        chk("to_pulse_end", 32'(pre_rr), 32'd0);
        chk("to_stay_3", 32'(grant_rr), 32'h8);
`endif

        // Asynchronous reset while master 3 owns the bus.
        drive(4'b1000);
        after_edge();
        chk("mid_owner_3", 32'(grant_rr), 32'h8);
        mon_en = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant_rr), 32'h4);
        chk("mid_rst_id", 32'(id_rr), 32'd2);
        chk("mid_rst_grant_fx", 32'(grant_fx), 32'h4);
        chk("mid_rst_preempt", 32'(pre_rr), 32'd0);
        model_reset();
        req = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised traffic with runs of repeated vectors and idle gaps.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 6) == 0) r = 4'b0000;
                else r = 4'($urandom_range(0, 15));
            end
            drive(r);
        end
        after_edge();
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
